// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan controller.
// Contents: display constants, hex font table, digit index type, frame
// buffer payload and the frame-load helper.
// Build option: SEG7_LEAD_ZERO_BLANK_EN adds leading-zero suppression to the
// frame-load helper.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned SEG_W      = 7;

  localparam logic [SEG_W-1:0]      SEG_BLANK = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = 4'hF;

  typedef logic [1:0] digit_idx_t;

  // Active-low {g,f,e,d,c,b,a} patterns for 0..F
  localparam logic [SEG_W-1:0] HEX_FONT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Frame buffer payload captured once per frame
  typedef struct packed {
    logic [NUM_DIGITS*NIB_W-1:0] digits;
    logic [NUM_DIGITS-1:0]       dp;
    logic [NUM_DIGITS-1:0]       blank;
  } frame_t;

  // Builds the buffered frame; the blank mask is final at load time
  function automatic frame_t load_frame(input logic [NUM_DIGITS*NIB_W-1:0] d,
                                        input logic [NUM_DIGITS-1:0]       p,
                                        input logic [NUM_DIGITS-1:0]       b);
    frame_t f;
`ifdef SEG7_LEAD_ZERO_BLANK_EN
    logic upper_zero;
`endif
    f.digits = d;
    f.dp     = p;
    f.blank  = b;
`ifdef SEG7_LEAD_ZERO_BLANK_EN
    // Walk down from the top digit while every nibble seen so far is zero;
    // digit 0 is never suppressed, a dp keeps its digit visible.
    upper_zero = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
      upper_zero = upper_zero & (d[i*NIB_W +: NIB_W] == 4'h0);
      if (upper_zero && !p[i]) f.blank[i] = 1'b1;
    end
`endif
    return f;
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
// Ports: nibble (4-bit value in), seg_c (7-bit {g..a} pattern out, unregistered).
module hex7seg
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [SEG_W-1:0] seg_c
);

  assign seg_c = HEX_FONT[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Ports: clk, rst_n (async active-low), en (scan enable), digits (4 nibbles,
// [3:0] rightmost), dp_in / blank (per-digit requests), digit_sel (mux-tree
// select), frame_start (pulse after wrap to digit 0), an / seg / dp
// (active-low pin drives, registered).
// Build option: SEG7_LEAD_ZERO_BLANK_EN enables leading-zero blanking.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned CNT_W       = 20
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [NUM_DIGITS*NIB_W-1:0] digits,
  input  logic [NUM_DIGITS-1:0]       dp_in,
  input  logic [NUM_DIGITS-1:0]       blank,
  output digit_idx_t                  digit_sel,
  output logic                        frame_start,
  output logic [NUM_DIGITS-1:0]       an,
  output logic [SEG_W-1:0]            seg,
  output logic                        dp
);

  localparam logic [CNT_W-1:0] TICK_VAL = CNT_W'(REFRESH_DIV - 1);
  localparam digit_idx_t       LAST_SEL = digit_idx_t'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt, cnt_n;
  digit_idx_t            sel_n;
  frame_t                fb, fb_n;
  logic                  loaded, loaded_n;
  logic                  run, run_n;
  logic [NUM_DIGITS-1:0] an_n;
  logic [SEG_W-1:0]      seg_n, seg_c;
  logic                  dp_n;
  logic                  tick, drive, wrap;
  logic [NIB_W-1:0]      nib;
  logic                  slot_blank;

  hex7seg u_dec (
    .nibble (nib),
    .seg_c  (seg_c)
  );

  // Scan control, frame loading and next pin values
  always_comb begin
    cnt_n    = cnt;
    sel_n    = digit_sel;
    fb_n     = fb;
    loaded_n = loaded;
    run_n    = run;
    an_n     = an;
    seg_n    = seg;
    dp_n     = dp;
    drive    = 1'b0;
    wrap     = 1'b0;
    tick     = (cnt == TICK_VAL);

    if (!en) begin
      // Display dark; counters freeze so the slot resumes where it stopped
      an_n  = AN_OFF;
      run_n = 1'b0;
    end else if (!run) begin
      // (Re)start of scanning: redrive the current slot with a fresh period
      cnt_n = '0;
      run_n = 1'b1;
      drive = 1'b1;
      if (!loaded) begin
        fb_n     = load_frame(digits, dp_in, blank);
        loaded_n = 1'b1;
      end
    end else if (tick) begin
      cnt_n = '0;
      sel_n = digit_sel + 2'd1;
      drive = 1'b1;
      if (digit_sel == LAST_SEL) begin
        wrap = 1'b1;
        fb_n = load_frame(digits, dp_in, blank);
      end
    end else begin
      cnt_n = cnt + CNT_W'(1);
    end

    // Decode from the post-load buffer so the wrap slot shows new data
    nib        = fb_n.digits[{sel_n, 2'b00} +: NIB_W];
    slot_blank = fb_n.blank[sel_n];
    if (drive) begin
      an_n  = ~(NUM_DIGITS'(1) << sel_n);
      seg_n = slot_blank ? SEG_BLANK : seg_c;
      dp_n  = ~(fb_n.dp[sel_n] & ~slot_blank);
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      digit_sel   <= '0;
      fb          <= '0;
      loaded      <= 1'b0;
      run         <= 1'b0;
      an          <= AN_OFF;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      cnt         <= cnt_n;
      digit_sel   <= sel_n;
      fb          <= fb_n;
      loaded      <= loaded_n;
      run         <= run_n;
      an          <= an_n;
      seg         <= seg_n;
      dp          <= dp_n;
      frame_start <= wrap;
    end
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexed driver for the board's 4-digit common-anode seven-segment display.
- Generates the rotating digit select that steers the 2:1 mux tree choosing which nibble is shown.
- Takes the selected hex nibble through a registered decoder and drives anodes and segments.
- Sits between the datapath muxes and the board pins; holds a frame buffer so a digit never changes mid-frame.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz/digit at 100 MHz); legal range 2..2^20.
- CNT_W, 20, prescaler width; must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scan enable; low blanks the display and freezes scanning
- digits  in  16  four hex nibbles; [3:0] is digit 0 (rightmost)
- dp_in  in  4  decimal point request per digit, active-high
- blank  in  4  per-digit blank request, active-high
- digit_sel  out  2  current digit index; feeds the mux-tree select lines
- frame_start  out  1  one-cycle pulse when digit_sel wraps to 0
- an  out  4  anodes, active-low, one-hot-low
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low

Behaviour:
- Reset (async, rst_n=0): prescaler=0, digit_sel=0, frame buffer=0, an=4'b1111, seg=7'b1111111, dp=1, frame_start=0.
- Prescaler counts 0..REFRESH_DIV-1 while en=1. tick = (prescaler==REFRESH_DIV-1). On tick: prescaler->0 and digit_sel advances 0->1->2->3->0.
- Frame buffer (digits, dp_in, blank) loads on the tick where digit_sel goes 3->0, and once out of reset on the first cycle with en=1. Inputs are ignored between loads.
- frame_start is high for exactly the one cycle after the 3->0 edge.
- an, seg and dp are registered and update on the same edge as digit_sel.
  - an = ~(1<<digit_sel).
  - seg = decode(buffer nibble[digit_sel]).
  - dp = ~buffer dp[digit_sel].
  - The digit-0 slot after a wrap uses the newly loaded buffer values.
- Blanking:
  - blank[i]=1 in the buffer: seg=7'h7F and dp=1 for that slot; the anode still scans.
  - en=0: an=4'b1111 on the next edge; prescaler and digit_sel hold.
  - When en returns to 1, the current slot is redriven and its full REFRESH_DIV period restarts from prescaler=0.
- Decode follows the standard hex font. Examples: 0->7'b1000000, 8->7'b0000000, A->7'b0001000, F->7'b0001110.
- If rst_n is asserted mid-frame, everything returns to reset values immediately. The first slot after release is digit 0 with freshly loaded data.

Optional Feature:
- Macro: SEG7_LEAD_ZERO_BLANK_EN.
- Defined: zero digits above the most-significant nonzero digit are blanked, unless they carry a dp. Digit 0 always displays. This is computed from the frame buffer at load time.
- Undefined: all four digits display as given; only the blank input suppresses a digit.

Decomposition:
- Package seg7_pkg holds:
  - SEG_BLANK = 7'h7F
  - AN_OFF = 4'hF
  - NUM_DIGITS = 4
  - a 16-entry hex font constant array
  - typedef digit_idx_t (2-bit)
- Sub-module hex7seg: a purely combinational nibble-to-segment decoder using the package font. The top level registers its output.

Test Plan:
- Reset/scan, REFRESH_DIV=4, digits=16'h1234, en=1 → an cycles 1110,1101,1011,0111 every 4 clk. seg shows 4,3,2,1 (7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001). frame_start pulses every 16 clk.
- Tearing: change digits to 16'hABCD while digit_sel=1 → slots 2 and 3 still show 2 and 1; the next frame shows D,C,B,A.
- Enable: drop en for 10 clk while digit_sel=2 → an=1111 throughout, digit_sel stays 2. After re-enable, slot 2 lasts a full 4 clk.
- Blank/dp: blank=4'b0100, dp_in=4'b0001 → slot 2 seg=7'h7F with anode low; slot 0 dp=0, others dp=1.
- Async reset: pulse rst_n low mid-slot 3, off clock edge → outputs go to reset values with no clock edge. After release, slot 0 displays the current digits[3:0].
- With SEG7_LEAD_ZERO_BLANK_EN: digits=16'h0050 → slots 3,2 blanked; slot 1 shows 5, slot 0 shows 0.
